// File: rtl/full_adder_pkg.sv
// Shared constants and reference arithmetic for the full_adder block.
package full_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;
  localparam int unsigned WIDTH_MAX     = 64;

  // Plain-arithmetic sum over the widest legal operand, carry kept in the top bit.
  function automatic logic [WIDTH_MAX:0] ref_add(input logic [WIDTH_MAX-1:0] x,
                                                 input logic [WIDTH_MAX-1:0] y,
                                                 input logic                 cin);
    return {1'b0, x} + {1'b0, y} + {{WIDTH_MAX{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full-adder cell; the ripple chain is formed by the parent.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic out,
  output logic c_out
);

  logic prop;

  assign prop  = a ^ b;
  assign out   = prop ^ c_in;
  assign c_out = (a & b) | (c_in & prop);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// Defining FULL_ADDER_SELFCHECK_EN adds a reference adder and a sticky err output.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
`ifdef FULL_ADDER_SELFCHECK_EN
  output logic             err,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = c_in;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    fa_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .out   (sum[i]),
      .c_out (carry[i+1])
    );
  end

  // Result registers only load on accepted operations; idle inputs never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out   <= sum;
        c_out <= carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_SELFCHECK_EN
  logic [WIDTH_MAX:0] ref_sum;
  logic               mismatch;

  assign ref_sum  = ref_add(WIDTH_MAX'(a), WIDTH_MAX'(b), c_in);
  assign mismatch = ref_sum != (WIDTH_MAX+1)'({carry[WIDTH], sum});

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_valid && mismatch) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16; honours FULL_ADDER_SELFCHECK_EN.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v1, ci1, co1, ov1;
  logic [0:0]  a1, b1, o1;
  logic        v8, ci8, co8, ov8;
  logic [7:0]  a8, b8, o8;
  logic        v16, ci16, co16, ov16;
  logic [15:0] a16, b16, o16;
`ifdef FULL_ADDER_SELFCHECK_EN
  logic        e1, e8, e16;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(ci1),
    .out(o1), .c_out(co1),
`ifdef FULL_ADDER_SELFCHECK_EN
    .err(e1),
`endif
    .out_valid(ov1));

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(ci8),
    .out(o8), .c_out(co8),
`ifdef FULL_ADDER_SELFCHECK_EN
    .err(e8),
`endif
    .out_valid(ov8));

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c_in(ci16),
    .out(o16), .c_out(co16),
`ifdef FULL_ADDER_SELFCHECK_EN
    .err(e16),
`endif
    .out_valid(ov16));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tab1[8];
  vec_t tab8[6];
  logic [7:0]  hold_s;
  logic [15:0] exp_s;
  logic        exp_co, exp_ov, rst_now;
  longint      r;

  initial begin
    // Expected {c_out,out} for (a,b,c_in) = 000..111: 00,01,01,10,01,10,10,11
    tab1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tab1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
    tab1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
    tab1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tab1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tab1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
    tab1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
    tab1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
    tab8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tab8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tab8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tab8[3] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
    tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tab8[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    v8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    v16 = 0; a16 = 0; b16 = 0; ci16 = 0;
    step();
    step();
    check("rst_w1", {ov1, co1, o1}, 64'd0);
    check("rst_w8", {ov8, co8, o8}, 64'd0);
    check("rst_w16", {ov16, co16, o16}, 64'd0);
`ifdef FULL_ADDER_SELFCHECK_EN
    check("rst_err", {e1, e8, e16}, 64'd0);
`endif
    rst = 1'b0;

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; a1 = tab1[i].a[0]; b1 = tab1[i].b[0]; ci1 = tab1[i].ci;
      step();
      check($sformatf("w1_vec%0d", i), {ov1, co1, o1}, {61'd0, 1'b1, tab1[i].co, tab1[i].s[0]});
    end
    v1 = 1'b0;

    // WIDTH=8 boundary vectors, back-to-back
    for (int i = 0; i < 6; i++) begin
      v8 = 1'b1; a8 = tab8[i].a; b8 = tab8[i].b; ci8 = tab8[i].ci;
      step();
      check($sformatf("w8_vec%0d", i), {ov8, co8, o8}, {54'd0, 1'b1, tab8[i].co, tab8[i].s});
    end

    // One op, then idle with random and unknown inputs: outputs hold
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; v8 = 1'b1;
    hold_s = 8'h46;
    step();
    check("hold_load", {ov8, co8, o8}, {54'd0, 1'b1, 1'b0, hold_s});
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a8 = 'x; b8 = 'x; ci8 = 1'bx;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      step();
      check($sformatf("hold_idle%0d", i), {ov8, co8, o8}, {54'd0, 1'b0, 1'b0, hold_s});
    end

    // Reset wins over a simultaneous valid op
    rst = 1'b1; v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
    step();
    check("rst_vs_valid", {ov8, co8, o8}, 64'd0);
    rst = 1'b0; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b1;
    step();
    check("post_rst_op", {ov8, co8, o8}, {54'd0, 1'b1, 1'b0, 8'h81});
    v8 = 1'b0;

    // WIDTH=16 streaming against an arithmetic model; full rate, then gaps and a reset
    exp_s = '0; exp_co = 1'b0; exp_ov = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      v16  = (i < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rst_now = (i == 1100) || (i == 1200 && v16);
      rst  = rst_now;
      a16  = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      if (rst_now) begin
        exp_s = '0; exp_co = 1'b0; exp_ov = 1'b0;
      end else begin
        exp_ov = v16;
        if (v16) begin
          r = longint'(a16) + longint'(b16) + longint'(ci16);
          exp_s  = 16'(r % 65536);
          exp_co = (r >= 65536);
        end
      end
      step();
      check($sformatf("w16_stream%0d", i), {ov16, co16, o16}, {46'd0, exp_ov, exp_co, exp_s});
    end
    rst = 1'b0; v16 = 1'b0;

`ifdef FULL_ADDER_SELFCHECK_EN
    check("err_w1", 64'(e1), 64'd0);
    check("err_w8", 64'(e8), 64'd0);
    check("err_w16", 64'(e16), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  qualifies a, b and c_in for sampling on this edge.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 c_in  input  1  carry into bit 0.
REQ-009 out  output  WIDTH  registered sum bits, (a+b+c_in) mod 2^WIDTH.
REQ-010 c_out  output  1  registered carry out of bit WIDTH-1.
REQ-011 out_valid  output  1  high for one cycle per accepted operation.
REQ-012 err  output  1  self-check mismatch flag; present only when FULL_ADDER_SELFCHECK_EN is defined.

Function
REQ-013 Per bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = c_in; ripple-carry chain.
REQ-014 {c_out, out} SHALL equal the (WIDTH+1)-bit result of a + b + c_in; no truncation of the carry.
REQ-015 Latency: when in_valid=1 at edge N, out and c_out update at edge N and out_valid=1 after edge N.
REQ-016 When in_valid=0 at an edge, out and c_out hold their previous values and out_valid=0.
REQ-017 Back-to-back in_valid=1 SHALL be accepted every cycle; no stall and no backpressure input.
REQ-018 Boundary: all-ones + all-ones + 1 -> out all-ones, c_out=1; zero + zero + 0 -> out 0, c_out=0.
REQ-019 Inputs when in_valid=0 SHALL have no effect on any output, including X values.

Reset
REQ-020 While rst=1 at an edge: out=0, c_out=0, out_valid=0, err=0.
REQ-021 rst SHALL take precedence over in_valid in the same cycle; that operation is discarded.
REQ-022 Reset mid-stream: the first valid after rst deasserts SHALL produce a correct result one edge later.

Configuration
REQ-023 Macro FULL_ADDER_SELFCHECK_EN defined: a behavioural reference computes a+b+c_in on accepted inputs; err is registered and set to 1 on the edge where it differs from the ripple result, sticky until rst.
REQ-024 Macro FULL_ADDER_SELFCHECK_EN undefined: no err port and no reference logic; all other behaviour identical.

Structure
REQ-025 Package full_adder_pkg holds the WIDTH_DEFAULT constant (1) and the WIDTH_MAX constant (64).
REQ-026 The 1-bit combinational cell (a, b, c_in -> out, c_out) SHALL be the sub-module fa_cell, instantiated WIDTH times by generate.
REQ-027 Output registers and the valid pipeline live in full_adder only.

Verification
REQ-028 WIDTH=1, exhaustively apply all 8 (a,b,c_in) combinations with in_valid=1 -> {c_out,out} = 00,01,01,10,01,10,10,11 one edge later.
REQ-029 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> out=0x00, c_out=1; then a=0xFF, b=0xFF, c_in=1 -> out=0xFF, c_out=1.
REQ-030 Apply a valid op, then hold in_valid=0 for 3 cycles with random a/b -> out and c_out unchanged, out_valid=0.
REQ-031 Assert rst together with in_valid=1 (a=1, b=1) -> out=0, c_out=0, out_valid=0; the next valid op after reset is correct.
REQ-032 WIDTH=16, random streaming at full rate for 1000 cycles -> every result matches the model; with FULL_ADDER_SELFCHECK_EN defined, err stays 0.
